downsampled_moving_avg: RTL and testbench

//   Boxcar (moving-average) filter for the decimated stream of two_stage_downsampler.
//   - Connect ce_in to the downsampler's ce_out_1 and data_in to its Out2.
//   - Averages the last 2**LOG2_LEN accepted samples.
//   - Emits one averaged sample, with a one-cycle strobe, per accepted input.
//   - Provides a smoothed low-rate stream for monitoring and logging.

---
 rtl/downsampled_moving_avg.sv | 80 ++++++++
 tb/tb_downsampled_moving_avg.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/downsampled_moving_avg.sv
// Boxcar average over the last 2**LOG2_LEN accepted samples of a decimated stream.
// One averaged sample (with a one-cycle ce_out strobe) is produced per accepted input,
// two clock edges after its ce_in strobe.
module downsampled_moving_avg #(
   parameter int DATA_WIDTH = 12,
   parameter int LOG2_LEN   = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ce_in,
   input  logic                         flush,
   input  logic signed [DATA_WIDTH-1:0] data_in,
   output logic signed [DATA_WIDTH-1:0] data_out,
   output logic                         ce_out,
   output logic                         filled
);

   localparam int N  = 1 << LOG2_LEN;
   localparam int SW = DATA_WIDTH + LOG2_LEN;   // N full-scale samples cannot overflow this

   logic [N-1:0][DATA_WIDTH-1:0] win_q;         // circular window, zero = empty slot
   logic [LOG2_LEN-1:0]          wr_ptr;
   logic [LOG2_LEN:0]            fill_cnt;      // saturates at N
   logic signed [SW-1:0]         sum_q;
   logic signed [SW-1:0]         sum_nxt;
   logic signed [DATA_WIDTH-1:0] oldest;
   logic                         accept;
   logic                         pend;          // accepted last edge, output due this edge

   // A strobe coinciding with flush is dropped.
   assign accept = ce_in & ~flush;
   assign oldest = win_q[wr_ptr];

   // Running sum: add the newcomer, drop the sample it overwrites.
   always_comb begin
      sum_nxt = sum_q + SW'(data_in) - SW'(oldest);
   end

   // Window storage, running sum, write pointer and fill count.
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         win_q    <= '0;
         sum_q    <= '0;
         wr_ptr   <= '0;
         fill_cnt <= '0;
      end else if (accept) begin
         win_q[wr_ptr] <= data_in;
         sum_q         <= sum_nxt;
         wr_ptr        <= wr_ptr + 1'b1;
         if (fill_cnt != (LOG2_LEN+1)'(N))
            fill_cnt <= fill_cnt + 1'b1;
      end
   end

   // Pending-output flag; a flush cycle still lets the previous accept fire.
   always_ff @(posedge clk) begin
      if (!reset)
         pend <= 1'b0;
      else
         pend <= accept;
   end

   // Output stage: scale the sum by 1/N (floor) one edge after the accept.
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_out <= '0;
         ce_out   <= 1'b0;
         filled   <= 1'b0;
      end else begin
         ce_out <= pend;
         if (pend)
            data_out <= DATA_WIDTH'(sum_q >>> LOG2_LEN);
         if (flush)
            filled <= 1'b0;
         else if (pend)
            filled <= (fill_cnt == (LOG2_LEN+1)'(N));
      end
   end

endmodule

// File: tb/tb_downsampled_moving_avg.sv
// Directed bench for downsampled_moving_avg (N=8, DATA_WIDTH=12).
module tb_downsampled_moving_avg;

   logic               clk = 1'b0;
   logic               reset;
   logic               ce_in;
   logic               flush;
   logic signed [11:0] data_in;
   logic signed [11:0] data_out;
   logic               ce_out;
   logic               filled;

   int n_chk = 0;
   int n_err = 0;

   downsampled_moving_avg #(.DATA_WIDTH(12), .LOG2_LEN(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .ce_in    (ce_in),
      .flush    (flush),
      .data_in  (data_in),
      .data_out (data_out),
      .ce_out   (ce_out),
      .filled   (filled)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Isolated strobe; output checked 2 edges later, then idle to 11 cycles total.
   task automatic feed(input int val, input int exp_out, input int exp_fill, input string tag);
      ce_in   = 1'b1;
      data_in = 12'(val);
      tick();
      ce_in   = 1'b0;
      data_in = '0;
      chk({tag, " early"}, ce_out, 0);
      tick();
      chk({tag, " ce"}, ce_out, 1);
      chk({tag, " out"}, data_out, exp_out);
      chk({tag, " fill"}, filled, exp_fill);
      tick();
      chk({tag, " ce off"}, ce_out, 0);
      chk({tag, " held"}, data_out, exp_out);
      repeat (8) tick();
   endtask

   int exp2 [8]  = '{12, 25, 37, 50, 62, 75, 87, 100};
   int exp3 [8]  = '{87, 75, 62, 50, 37, 25, 12, 0};
   int exp4 [24] = '{-1, -1, -1, -1, -1, -1, -1, -1,
                     255, 511, 767, 1023, 1279, 1535, 1791, 2047,
                     1535, 1023, 511, -1, -513, -1025, -1537, -2048};
   int in4  [24];

   initial begin
      int pulses;
      reset   = 1'b0;
      ce_in   = 1'b1;
      flush   = 1'b0;
      data_in = 12'sd500;

      // 1: reset held with active strobes
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rst out", data_out, 0);
         chk("rst ce", ce_out, 0);
         chk("rst fill", filled, 0);
      end
      reset = 1'b1;
      ce_in = 1'b0;
      tick();
      chk("post rst ce", ce_out, 0);

      // 2: ramp up with 100s
      for (int i = 0; i < 8; i++)
         feed(100, exp2[i], (i == 7) ? 1 : 0, $sformatf("fill%0d", i));

      // 3: wrap-around with zeros
      for (int i = 0; i < 8; i++)
         feed(0, exp3[i], 1, $sformatf("wrap%0d", i));

      // 4: back-to-back strobes, full-scale values
      for (int i = 0; i < 24; i++)
         in4[i] = (i < 8) ? -1 : (i < 16) ? 2047 : -2048;
      pulses = 0;
      for (int i = 0; i < 26; i++) begin
         ce_in   = (i < 24);
         data_in = (i < 24) ? 12'(in4[i]) : '0;
         tick();
         if (ce_out) pulses++;
         if (i >= 1 && i <= 24) begin
            chk($sformatf("b2b ce%0d", i-1), ce_out, 1);
            chk($sformatf("b2b out%0d", i-1), data_out, exp4[i-1]);
         end
      end
      ce_in = 1'b0;
      tick();
      chk("b2b pulses", pulses, 24);
      chk("b2b fill", filled, 1);
      chk("b2b hold", data_out, -2048);

      // 5: refill with 100, then flush with a simultaneous strobe
      for (int i = 0; i < 8; i++) begin
         ce_in   = 1'b1;
         data_in = 12'sd100;
         tick();
      end
      ce_in = 1'b0;
      tick();
      tick();
      chk("refill out", data_out, 100);
      chk("refill fill", filled, 1);
      flush   = 1'b1;
      ce_in   = 1'b1;
      data_in = 12'sd800;
      tick();
      flush = 1'b0;
      ce_in = 1'b0;
      chk("flush fill", filled, 0);
      chk("flush hold", data_out, 100);
      chk("flush ce", ce_out, 0);
      tick();
      chk("flush drop ce", ce_out, 0);
      feed(80, 10, 0, "post flush");

      // pending output still fires in a flush cycle
      ce_in   = 1'b1;
      data_in = 12'sd8;
      tick();
      ce_in = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush pend ce", ce_out, 1);
      chk("flush pend out", data_out, 11);
      chk("flush pend fill", filled, 0);
      tick();

      // 6: reset cancels a pending output
      ce_in   = 1'b1;
      data_in = 12'sd160;
      tick();
      ce_in = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst pend ce", ce_out, 0);
      chk("rst pend out", data_out, 0);
      tick();
      chk("rst pend ce2", ce_out, 0);
      feed(40, 5, 0, "post rst");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
